// File: rtl/gcd_job_sequencer.sv
// ============================================================================
//  Module   : gcd_job_sequencer
//  Purpose  : Queues GCD operand pairs, sequences an external GCD core one job
//             at a time, short-circuits zero operands and returns results over
//             a valid/ready response port. Optional watchdog: GCD_SEQ_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_job_sequencer #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] core_in1,
    output logic [WIDTH-1:0] core_in2,
    output logic             core_rst,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_gcd,
    output logic             rsp_err,
    output logic             busy
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH_CNT = (c_PTR_W+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_BYPASS = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------------
    logic [2*WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    state_t             r_state;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [2*WIDTH-1:0] w_head;
    logic [WIDTH-1:0]   w_head_a;
    logic [WIDTH-1:0]   w_head_b;

    // Full blocks pushes even when a pop happens the same cycle.
    assign w_full    = (r_count == c_DEPTH_CNT);
    assign w_empty   = (r_count == '0);
    assign req_ready = reset & ~w_full;
    assign w_push    = req_valid & req_ready;
    assign w_pop     = (r_state == S_IDLE) & ~w_empty;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_head_a  = w_head[2*WIDTH-1:WIDTH];
    assign w_head_b  = w_head[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_a, req_b};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Job sequencer
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_core_in1;
    logic [WIDTH-1:0] r_core_in2;
    logic             r_core_rst;
    logic             r_load_cnt;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_gcd;

`ifdef GCD_SEQ_TIMEOUT_EN
    localparam int                c_WDOG_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(TIMEOUT - 1);

    logic                r_rsp_err;
    logic [c_WDOG_W-1:0] r_wdog;

    assign rsp_err = r_rsp_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^32'(TIMEOUT);
    assign rsp_err          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_opa       <= '0;
            r_opb       <= '0;
            r_core_in1  <= '0;
            r_core_in2  <= '0;
            r_core_rst  <= 1'b1;
            r_load_cnt  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_gcd   <= '0;
`ifdef GCD_SEQ_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
            r_wdog      <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_core_rst <= 1'b1;
                    if (!w_empty) begin
                        r_opa <= w_head_a;
                        r_opb <= w_head_b;
                        // gcd with a zero operand is just the other operand.
                        if ((w_head_a == '0) || (w_head_b == '0)) begin
                            r_state <= S_BYPASS;
                        end else begin
                            r_state    <= S_LOAD;
                            r_core_in1 <= w_head_a;
                            r_core_in2 <= w_head_b;
                            r_load_cnt <= 1'b0;
`ifdef GCD_SEQ_TIMEOUT_EN
                            r_wdog     <= '0;
`endif
                        end
                    end
                end

                S_LOAD: begin
                    if (r_load_cnt) begin
                        r_state    <= S_RUN;
                        r_core_rst <= 1'b0;
                    end else begin
                        r_load_cnt <= 1'b1;
                    end
                end

                S_RUN: begin
                    if (core_done) begin
                        r_rsp_gcd   <= core_out;
                        r_rsp_valid <= 1'b1;
                        r_core_rst  <= 1'b1;
                        r_state     <= S_HOLD;
`ifdef GCD_SEQ_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
                    end else if (r_wdog == c_WDOG_LAST) begin
                        r_rsp_gcd   <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_core_rst  <= 1'b1;
                        r_state     <= S_HOLD;
                    end else begin
                        r_wdog      <= r_wdog + 1'b1;
`endif
                    end
                end

                S_BYPASS: begin
                    r_rsp_gcd   <= r_opa | r_opb;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_HOLD;
`ifdef GCD_SEQ_TIMEOUT_EN
                    r_rsp_err   <= 1'b0;
`endif
                end

                S_HOLD: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_core_rst  <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign core_in1  = r_core_in1;
    assign core_in2  = r_core_in2;
    assign core_rst  = r_core_rst;
    assign rsp_valid = r_rsp_valid;
    assign rsp_gcd   = r_rsp_gcd;
    assign busy      = (r_state != S_IDLE) | ~w_empty;

endmodule

`default_nettype wire

// File: doc/gcd_job_sequencer.md
GCD_JOB_SEQUENCER -- requirements
Module: gcd_job_sequencer

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, operand/result bit width; DEPTH, default 4, request FIFO entries (power of 2, >=2); TIMEOUT, default 4096, watchdog limit in cycles.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 req_valid  in  1  request operand pair valid.
REQ-005 req_ready  out  1  FIFO not full; transfer when req_valid&req_ready.
REQ-006 req_a, req_b  in  WIDTH each  request operands.
REQ-007 core_in1, core_in2  out  WIDTH each  operands driven to the downstream GCD core.
REQ-008 core_rst  out  1  active-high reset/start to the GCD core.
REQ-009 core_done  in  1  core completion flag (level, held until core reset).
REQ-010 core_out  in  WIDTH  core result, valid while core_done=1.
REQ-011 rsp_valid  out  1  result available; rsp_ready  in  1  consumer accepts; rsp_gcd  out  WIDTH  result.
REQ-012 rsp_err  out  1  result aborted by watchdog; busy  out  1  FSM not IDLE or FIFO non-empty.

Function
REQ-013 FIFO SHALL store {req_a,req_b}; push on req_valid&req_ready; simultaneous push and pop when full is NOT allowed (req_ready=0 when count==DEPTH, regardless of pop).
REQ-014 Pointers SHALL wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-015 FSM states: IDLE, LOAD, RUN, BYPASS, HOLD.
REQ-016 IDLE: if FIFO non-empty, pop head into operand registers opA/opB, go BYPASS if opA==0 or opB==0, else LOAD.
REQ-017 LOAD: core_rst=1 for exactly 2 cycles, core_in1/core_in2 = opA/opB, then RUN.
REQ-018 RUN: core_rst=0, core_in1/core_in2 held stable; core_done sampled only in RUN; on core_done=1 capture core_out into rsp_gcd, rsp_err=0, go HOLD.
REQ-019 BYPASS (one cycle): rsp_gcd = opA|opB (gcd(0,x)=x, gcd(0,0)=0), rsp_err=0, go HOLD; core untouched.
REQ-020 HOLD: rsp_valid=1, rsp_gcd/rsp_err stable; on rsp_ready=1 go IDLE; rsp_valid SHALL drop the cycle after acceptance.
REQ-021 core_rst SHALL be 1 in IDLE, BYPASS and HOLD (core held reset while unused); 0 only in RUN.
REQ-022 Latency, empty FIFO and IDLE: push at cycle N, pop at N+1, LOAD N+2..N+3, RUN from N+4; rsp_valid the cycle after core_done sampled; bypass: rsp_valid at N+3.
REQ-023 Pushes SHALL continue during LOAD/RUN/HOLD; at most one job in flight.

Reset
REQ-024 reset=0 SHALL force: FSM IDLE, FIFO empty, req_ready=0 during reset then 1, rsp_valid=0, rsp_gcd=0, rsp_err=0, core_rst=1, core_in1/core_in2=0, busy=0, watchdog=0.
REQ-025 Reset mid-operation SHALL discard in-flight job and FIFO contents; no response emitted.

Configuration
REQ-026 Macro GCD_SEQ_TIMEOUT_EN defined: watchdog counts RUN cycles; on reaching TIMEOUT without core_done, rsp_gcd=0, rsp_err=1, go HOLD; counter cleared on entering LOAD.
REQ-027 Macro undefined: no watchdog logic, RUN waits indefinitely, rsp_err tied 0.

Verification
REQ-028 Push (48,18), rsp_ready=1 -> core sees 2-cycle core_rst, rsp_gcd=6, rsp_err=0, one-cycle rsp_valid pulse.
REQ-029 Push (0,35) then (0,0) -> rsp_gcd=35 then 0, each rsp_valid 2 cycles after pop, core_rst never low.
REQ-030 rsp_ready=0, push 6 jobs back-to-back (DEPTH=4) -> req_ready=0 after 5 accepted (1 in flight + 4 queued), results in push order once rsp_ready=1.
REQ-031 reset=0 for one cycle during RUN of (1071,462) -> no response, busy=0, next job (21,14) yields 7.
REQ-032 GCD_SEQ_TIMEOUT_EN, TIMEOUT=16, core_done stuck 0 -> rsp_valid with rsp_gcd=0, rsp_err=1 exactly 16 RUN cycles after LOAD exit.
